// File: rtl/serial_circular_shifter_if.sv
// Request/result bundle for the serial circular shifter.
// The shifter is the slave; the producer/consumer side is the master.
interface serial_circular_shifter_if #(
  parameter int N  = 8,
  parameter int SW = $clog2(N)
);
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic [SW-1:0] in_shift;
  logic          in_dir;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_data;

  modport master (
    output in_valid, in_data, in_shift, in_dir, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_shift, in_dir, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/serial_circular_shifter.sv
// Multi-cycle circular shifter: rotates a word one bit per clock until the
// requested amount is consumed, then holds the result until it is taken.
module serial_circular_shifter #(
  parameter int N  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic                     clk,
  input  logic                     rst,
  serial_circular_shifter_if.slave bus,
  output logic                     busy
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t        state;
  logic [N-1:0]  data_reg;
  logic [SW-1:0] cnt;
  logic          dir_reg;
  logic          in_ready_reg;
  logic          out_valid_reg;
  logic [SW-1:0] shift_mod;
  logic [N-1:0]  rot_left;
  logic [N-1:0]  rot_right;

  // Amounts of N or more wrap around; only reachable when N is not a power of two.
  assign shift_mod = SW'(int'(bus.in_shift) % N);

  assign rot_left  = {data_reg[N-2:0], data_reg[N-1]};
  assign rot_right = {data_reg[0], data_reg[N-1:1]};

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = data_reg;

  // Handshake flags are flops updated alongside the state, so neither
  // in_ready nor out_valid has a combinational path from the other port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      data_reg      <= '0;
      cnt           <= '0;
      dir_reg       <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      busy          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            data_reg     <= bus.in_data;
            dir_reg      <= bus.in_dir;
            cnt          <= shift_mod;
            in_ready_reg <= 1'b0;
            busy         <= 1'b1;
            if (shift_mod != '0) begin
              state <= SHIFT;
            end else begin
              state         <= DONE;
              out_valid_reg <= 1'b1;
            end
          end
        end

        SHIFT: begin
          data_reg <= dir_reg ? rot_right : rot_left;
          cnt      <= cnt - SW'(1);
          if (cnt == SW'(1)) begin
            state         <= DONE;
            out_valid_reg <= 1'b1;
          end
        end

        DONE: begin
          // Returning to IDLE first leaves one bubble before the next accept.
          if (bus.out_ready) begin
            state         <= IDLE;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            busy          <= 1'b0;
          end
        end

        default: begin
          state         <= IDLE;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
          busy          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_circular_shifter.sv
// Scoreboard bench for serial_circular_shifter: stimulus pushes expected
// results, a negedge monitor pops and compares on each output handshake.
module tb_serial_circular_shifter;

  localparam int N  = 8;
  localparam int SW = 3;

  localparam int MODE_READY  = 0;
  localparam int MODE_HOLD   = 1;
  localparam int MODE_RANDOM = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy;
  int   mode = MODE_READY;

  int compared   = 0;
  int mismatched = 0;
  int issued     = 0;
  int popped     = 0;

  logic [N-1:0] sb[$];

  serial_circular_shifter_if #(.N(N), .SW(SW)) bus ();

  serial_circular_shifter #(.N(N), .SW(SW)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  // Reference rotate built bit-by-bit from index arithmetic.
  function automatic logic [N-1:0] rot_ref(input logic [N-1:0] d, input int s, input logic dir);
    logic [N-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      if (!dir) r[(i + s) % N] = d[i];
      else      r[i] = d[(i + s) % N];
    end
    return r;
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic bounded_fail(input string name);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: timed out at %0t", name, $time);
  endtask

  // Present a request and hold it until an edge at which in_ready was high.
  task automatic apply_stimulus(input logic [N-1:0] d, input logic [SW-1:0] s, input logic dir,
                                input logic push);
    logic ready_before;
    int   waited;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_shift = s;
    bus.in_dir   = dir;
    waited = 0;
    do begin
      ready_before = bus.in_ready;
      @(posedge clk);
      #1;
      waited++;
    end while (!ready_before && waited < 200);
    if (!ready_before) bounded_fail("accept_wait");
    else if (push) begin
      sb.push_back(rot_ref(d, int'(s), dir));
      issued++;
    end
    bus.in_valid = 1'b0;
    bus.in_data  = N'($urandom);
    bus.in_shift = SW'($urandom);
    bus.in_dir   = 1'($urandom);
  endtask

  task automatic run_directed(input string name, input logic [N-1:0] d, input logic [SW-1:0] s,
                              input logic dir, input logic [N-1:0] expected);
    int cycles;
    apply_stimulus(d, s, dir, 1'b1);
    check_output({name, "_model"}, rot_ref(d, int'(s), dir), expected);
    if (s != 0) check_output({name, "_busy"}, busy, 1);
    cycles = 0;
    while (!bus.out_valid && cycles < 64) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    check_output({name, "_latency"}, cycles, s);
    @(posedge clk);
    #1;
    check_output({name, "_in_ready_after"}, bus.in_ready, 1);
    check_output({name, "_out_valid_after"}, bus.out_valid, 0);
  endtask

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        MODE_READY: bus.out_ready = 1'b1;
        MODE_HOLD:  bus.out_ready = 1'b0;
        default:    bus.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        bounded_fail("unexpected_result");
      end else begin
        check_output("result_data", bus.out_data, sb.pop_front());
        popped++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int waited;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_shift = '0;
    bus.in_dir   = 1'b0;

    #1 rst = 1'b1;
    #1;
    check_output("reset_in_ready", bus.in_ready, 1);
    check_output("reset_out_valid", bus.out_valid, 0);
    check_output("reset_busy", busy, 0);
    check_output("reset_out_data", bus.out_data, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] directed rotations");
    run_directed("rotl3",   8'b10110101, 3'd3, 1'b0, 8'b10101101);
    run_directed("rotr3",   8'b10110101, 3'd3, 1'b1, 8'b10110110);
    run_directed("rotr3_b", 8'b01100110, 3'd3, 1'b1, 8'b11001100);
    run_directed("zero",    8'b11010001, 3'd0, 1'b0, 8'b11010001);
    run_directed("rotr7",   8'b00000001, 3'd7, 1'b1, 8'b00000010);
    run_directed("rotl1",   8'b00000001, 3'd1, 1'b0, 8'b00000010);

    $display("[TB] backpressure and in-flight input changes");
    mode = MODE_HOLD;
    repeat (2) @(posedge clk);
    #1;
    apply_stimulus(8'b10110101, 3'd3, 1'b0, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hFF;
    bus.in_shift = 3'd1;
    bus.in_dir   = 1'b1;
    waited = 0;
    while (!bus.out_valid && waited < 64) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (!bus.out_valid) bounded_fail("bp_out_valid_wait");
    for (int i = 0; i < 10; i++) begin
      check_output("bp_out_valid", bus.out_valid, 1);
      check_output("bp_out_data", bus.out_data, 8'b10101101);
      check_output("bp_in_ready", bus.in_ready, 0);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    mode = MODE_READY;
    waited = 0;
    while (bus.out_valid && waited < 16) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check_output("bp_released_in_ready", bus.in_ready, 1);
    check_output("bp_scoreboard_empty", sb.size(), 0);
    @(posedge clk);
    #1;
    check_output("bp_no_duplicate", bus.out_valid, 0);

    $display("[TB] reset during shift");
    apply_stimulus(8'b00110011, 3'd5, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_output("pre_reset_busy", busy, 1);
    rst = 1'b1;
    #1;
    check_output("midreset_out_valid", bus.out_valid, 0);
    check_output("midreset_in_ready", bus.in_ready, 1);
    check_output("midreset_out_data", bus.out_data, 0);
    check_output("midreset_busy", busy, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    run_directed("after_reset", 8'b11110000, 3'd3, 1'b0, 8'b10000111);

    $display("[TB] random back-to-back traffic");
    mode = MODE_RANDOM;
    for (int n = 0; n < 200; n++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      apply_stimulus(N'($urandom), SW'($urandom), 1'($urandom), 1'b1);
    end
    waited = 0;
    while (sb.size() != 0 && waited < 2000) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check_output("drain_empty", sb.size(), 0);
    check_output("results_vs_requests", popped, issued);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
